// File: rtl/xyz_stepper.sv
// xyz_stepper: issues I-low step pulses to walk the xyz FSM to a target code.
// Optional output pulse_cnt is enabled by XYZ_STEPPER_PULSE_CNT_EN.
module xyz_stepper #(
    parameter int TIMEOUT_CYC = 4,
    parameter int TO_W        = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_code,
    input  logic [2:0] xyz_in,
    output logic       step_I,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
`ifdef XYZ_STEPPER_PULSE_CNT_EN
    ,
    output logic [7:0] pulse_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [1:0] EC_NONE = 2'b00;
    localparam logic [1:0] EC_TGT  = 2'b01;
    localparam logic [1:0] EC_XYZ  = 2'b10;
    localparam logic [1:0] EC_TO   = 2'b11;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    function automatic logic legal(input logic [2:0] c);
        return c inside {3'b000, 3'b001, 3'b010, 3'b100};
    endfunction

    function automatic logic [1:0] idx(input logic [2:0] c);
        case (c)
            3'b001:  idx = 2'd1;
            3'b010:  idx = 2'd2;
            3'b100:  idx = 2'd3;
            default: idx = 2'd0;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [1:0]      rem_q, rem_d;
    logic [1:0]      exp_q, exp_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [1:0]      ec_q, ec_d;
    logic [1:0]      tgt_w, cur_w;

    assign tgt_w = idx(req_code);
    assign cur_w = idx(xyz_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            exp_q   <= '0;
            to_q    <= '0;
            ec_q    <= EC_NONE;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            exp_q   <= exp_d;
            to_q    <= to_d;
            ec_q    <= ec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        exp_d   = exp_q;
        to_d    = to_q;
        ec_d    = ec_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rem_d = tgt_w - cur_w;
                    exp_d = cur_w;
                    to_d  = '0;
                    ec_d  = EC_NONE;
                    if (!legal(req_code)) begin
                        ec_d    = EC_TGT;
                        state_d = S_DONE;
                    end else if (!legal(xyz_in)) begin
                        ec_d    = EC_XYZ;
                        state_d = S_DONE;
                    end else if (tgt_w == cur_w) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_PULSE;
                    end
                end
            end
            S_PULSE: begin
                exp_d   = exp_q + 2'd1;
                to_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!legal(xyz_in)) begin
                    ec_d    = EC_XYZ;
                    state_d = S_DONE;
                end else if (cur_w == exp_q) begin
                    rem_d   = rem_q - 2'd1;
                    state_d = (rem_q == 2'd1) ? S_DONE : S_PULSE;
                end else begin
                    to_d = to_q + 1'b1;
                    if (to_q == TO_LAST) begin
                        ec_d    = EC_TO;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Every output is a decode of state or flops; step_I drops only in PULSE.
    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign step_I    = (state_q != S_PULSE);
    assign err_code  = ec_q;
    assign err       = (ec_q != EC_NONE);

`ifdef XYZ_STEPPER_PULSE_CNT_EN
    logic [7:0] pcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else if (state_q == S_PULSE) begin
            pcnt_q <= pcnt_q + 8'd1;
        end
    end

    assign pulse_cnt = pcnt_q;
`endif

endmodule

// File: tb/tb_xyz_stepper.sv
// tb_xyz_stepper: directed and random requests against a modelled xyz FSM.
// The expected outcome of each request is derived from code positions.
module tb_xyz_stepper;

    localparam int TIMEOUT_CYC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_code;
    logic [2:0] xyz = 3'b000;
    logic       step_I;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;
`ifdef XYZ_STEPPER_PULSE_CNT_EN
    logic [7:0] pulse_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int tot    = 0;
    bit prev_low = 1'b0;
    bit i_low    = 1'b0;
    bit frozen   = 1'b0;
    bit load     = 1'b0;
    logic [2:0] load_val = 3'b000;

    int         pos_tab  [8] = '{0, 1, 2, -1, 3, -1, -1, -1};
    logic [2:0] code_tab [4] = '{3'b000, 3'b001, 3'b010, 3'b100};

    xyz_stepper #(.TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_code (req_code),
        .xyz_in   (xyz),
        .step_I   (step_I),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code)
`ifdef XYZ_STEPPER_PULSE_CNT_EN
        ,
        .pulse_cnt(pulse_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor: counts I-low cycles, flags back-to-back lows.
    always @(negedge clk) begin
        if (!rst_n) begin
            tot      = 0;
            prev_low = 1'b0;
            i_low    = 1'b0;
        end else begin
            if (step_I === 1'b0) begin
                chk("no_back2back", 32'(prev_low), 0);
                tot++;
            end
            prev_low = (step_I === 1'b0);
            i_low    = (step_I === 1'b0);
        end
    end

    // Stepped FSM model: advances one code per I-low sampled at an edge.
    always @(posedge clk) begin
        if (load)
            xyz <= load_val;
        else if (i_low && !frozen && pos_tab[xyz] >= 0)
            xyz <= code_tab[(pos_tab[xyz] + 1) % 4];
    end

    task automatic do_req(input logic [2:0] code, input logic [2:0] start,
                          input bit frz);
        int tp, cp, steps, exp_ec, exp_cyc, exp_pul, base, dcyc;
        logic [2:0] exp_x;
        bit seen;
        tp = pos_tab[code];
        cp = pos_tab[start];
        steps = 0;
        if (tp < 0) exp_ec = 1;
        else if (cp < 0) exp_ec = 2;
        else begin
            exp_ec = 0;
            steps  = (tp - cp + 4) % 4;
        end
        exp_pul = steps;
        exp_cyc = 2 * steps + 1;
        exp_x   = (exp_ec == 0) ? code : start;
        if (frz && steps > 0) begin
            exp_ec  = 3;
            exp_pul = 1;
            exp_cyc = 2 + TIMEOUT_CYC;
            exp_x   = start;
        end
        @(negedge clk);
        load = 1'b1;
        load_val = start;
        frozen = frz;
        @(negedge clk);
        load = 1'b0;
        req_code = code;
        req_valid = 1'b1;
        base = tot;
        chk("req_ready_idle", 32'(req_ready), 1);
        seen = 1'b0;
        dcyc = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            if (c == 2) req_code = 3'($urandom);
            if (done === 1'b1) begin
                seen = 1'b1;
                dcyc = c;
            end else if (c == 1) begin
                chk("busy_run", 32'(busy), 1);
                chk("ready_run", 32'(req_ready), 0);
            end
        end
        if (!seen) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("done_cycle", 32'(dcyc), 32'(exp_cyc));
            chk("err", 32'(err), 32'(exp_ec != 0));
            chk("err_code", 32'(err_code), 32'(exp_ec));
            chk("pulses", 32'(tot - base), 32'(exp_pul));
            chk("final_xyz", 32'(xyz), 32'(exp_x));
            chk("ready_done", 32'(req_ready), 0);
`ifdef XYZ_STEPPER_PULSE_CNT_EN
            chk("pulse_cnt", 32'(pulse_cnt), 32'(tot % 256));
`endif
        end
        @(negedge clk);
        chk("done_1cyc", 32'(done), 0);
        chk("ready_after", 32'(req_ready), 1);
        chk("err_held", 32'(err), 32'(exp_ec != 0));
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_code = 3'b000;
        #2;
        chk("rst_step_I", 32'(step_I), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_err_code", 32'(err_code), 0);
        chk("rst_ready", 32'(req_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        do_req(3'b100, 3'b000, 1'b0);
        do_req(3'b001, 3'b100, 1'b0);
        do_req(3'b010, 3'b010, 1'b0);
        do_req(3'b011, 3'b000, 1'b0);
        do_req(3'b010, 3'b000, 1'b0);
        do_req(3'b001, 3'b000, 1'b1);
        do_req(3'b100, 3'b110, 1'b0);

        // Reset in the WAIT after the first of three pulses.
        @(negedge clk);
        load = 1'b1;
        load_val = 3'b000;
        frozen = 1'b0;
        @(negedge clk);
        load = 1'b0;
        req_code = 3'b100;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_step_I", 32'(step_I), 1);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_ready", 32'(req_ready), 1);
        chk("mid_rst_err_code", 32'(err_code), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(req_ready), 1);
`ifdef XYZ_STEPPER_PULSE_CNT_EN
        chk("post_rst_pcnt", 32'(pulse_cnt), 0);
`endif
        chk("post_rst_xyz", 32'(xyz), 32'(3'b001));
        do_req(3'b100, 3'b001, 1'b0);

        for (int i = 0; i < 24; i++) begin
            logic [2:0] code, start;
            bit frz;
            code  = ($urandom_range(0, 3) != 0) ?
                    code_tab[$urandom_range(0, 3)] : 3'($urandom);
            start = ($urandom_range(0, 5) != 0) ?
                    code_tab[$urandom_range(0, 3)] : 3'($urandom);
            frz   = ($urandom_range(0, 5) == 0);
            do_req(code, start, frz);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/xyz_stepper.md
Name: xyz_stepper

Overview:
Initiator-side sequencer for the zero-stepped xyz state FSM. It drives the FSM's step input I and reads the FSM's xyz code back. It accepts a target code over a valid/ready request, issues exactly the number of I-low step pulses needed to reach that code, and checks the xyz feedback after every pulse. It reports completion, a wrong target, an illegal feedback code, or a stalled FSM.

Parameters:
TIMEOUT_CYC, 4, max WAIT cycles allowed for xyz to reach the expected code after a pulse (1..15)
TO_W, 4, width of the timeout counter; must satisfy TIMEOUT_CYC < 2**TO_W

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  high only in IDLE
req_code  input  3  target xyz code
xyz_in  input  3  xyz code from the stepped FSM
step_I  output  1  drives FSM input I; idle high, low = one step
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle completion pulse
err  output  1  error flag, valid with done, held until next accept
err_code  output  2  00 none, 01 illegal target, 10 illegal xyz_in, 11 timeout

Behaviour:
- Index map: 000->0, 001->1, 010->2, 100->3. Any other 3-bit code is illegal.
- Reset (rst_n low, async): state=IDLE, step_I=1, done=0, err=0, err_code=00, busy=0, req_ready=1, counters cleared. Applies immediately, including mid-sequence. Any pulse in flight is truncated, step_I returns high at once.
- All outputs are decoded from registered state or flops only. There is no combinational path from inputs to outputs except req_ready, which depends on state only.
- Accept happens at a rising edge with req_valid && req_ready. At accept:
  - Latch tgt=idx(req_code) and cur=idx(xyz_in).
  - Compute remaining=(tgt-cur) mod 4 (2-bit wrap), exp=cur, to_cnt=0.
  - Clear err and err_code.
- Transitions out of IDLE on accept, in priority order:
  - req_code illegal -> DONE, err_code=01.
  - xyz_in illegal -> DONE, err_code=10.
  - remaining==0 -> DONE, err_code=00.
  - otherwise -> PULSE.
- PULSE (1 cycle): step_I=0, exp<=exp+1 mod 4, to_cnt<=0, next state WAIT.
- WAIT: step_I=1. Each cycle decode xyz_in:
  - xyz_in illegal -> DONE, err_code=10.
  - idx==exp -> remaining<=remaining-1; if remaining was 1 -> DONE, else -> PULSE.
  - otherwise to_cnt<=to_cnt+1; if to_cnt==TIMEOUT_CYC-1 -> DONE, err_code=11.
- DONE (1 cycle): done=1, err=(err_code!=00), req_ready=0, next state IDLE.
- Latency with a responsive FSM:
  - The FSM updates xyz one edge after sampling I low, so the first WAIT cycle matches.
  - Each step costs 2 cycles.
  - done rises 2*steps+1 cycles after the accept edge; 1 cycle for zero steps or an error at accept.
- req_valid or req_code changing while busy is ignored. No queuing.
- At most 3 pulses are issued per request, and step_I is never low for 2 consecutive cycles.

Optional Feature:
XYZ_STEPPER_PULSE_CNT_EN
- Defined: adds output pulse_cnt[7:0]. It increments by 1 on every cycle step_I is low, wraps 255->0, resets to 0 on rst_n, and is never cleared by requests.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Bench FSM model at xyz=000, req_code=100 -> 3 step_I low pulses, 2 cycles apart. done on cycle 7 after accept, err=0, final xyz=100.
- FSM at 100, req_code=001 -> 2 pulses (wrap 3->0->1). done on cycle 5, err=0.
- FSM at 010, req_code=010 -> no pulses, done on cycle 1, err=0, err_code=00.
- req_code=011 -> no pulses, done on cycle 1, err=1, err_code=01. Next request accepted normally and err cleared.
- FSM frozen (ignores I) at 000, req_code=001 -> 1 pulse, then 4 WAIT cycles. done with err=1, err_code=11.
- rst_n low in the WAIT after the 1st of 3 pulses -> step_I=1, busy=0, done=0 immediately. After release, req_ready=1. With PULSE_CNT_EN defined, pulse_cnt=0.
